// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter (TXDATA/STATUS registers) with a small transmit FIFO.
// Latency: byte pushed at edge N, start bit driven from edge N+1 when idle; frames run back to back.
// Backpressure: none on the bus; a write to a full FIFO is dropped and sets the sticky ovf flag.
//
// Ports: clk_i/rst_ni (async active-low); dbus_en_i/dbus_addr_i/dbus_write_data_i bus write side;
//        dbus_sel_o/dbus_read_data_o combinational decode and read data; tx_o serial line (idle high).
// Optional: define UART_TX_PARITY_EN to add an even-parity bit (STATUS bit4 then reads 1).
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  dbus_en_i,
    input  logic [31:0] dbus_addr_i,
    input  logic [31:0] dbus_write_data_i,
    output logic        dbus_sel_o,
    output logic [31:0] dbus_read_data_o,
    output logic        tx_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PARITY_FLAG = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ---------------- bus decode ----------------
    logic sel_txdata, sel_status;
    logic wr_req, ovf_clr;

    assign sel_txdata = (dbus_addr_i == BASE_ADDR);
    assign sel_status = (dbus_addr_i == STATUS_ADDR);
    assign dbus_sel_o = sel_txdata | sel_status;
    assign wr_req     = dbus_en_i[0] & sel_txdata;
    assign ovf_clr    = dbus_en_i[0] & sel_status & dbus_write_data_i[3];

    // Only lane 0 is meaningful; the remaining bus bits are intentionally dropped.
    logic unused_bus_bits;
    assign unused_bus_bits = &{1'b0, dbus_en_i[3:1], dbus_write_data_i[31:8]};

    // ---------------- transmit FIFO ----------------
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q, count;
    logic           full, empty, push, pop, ovf_q;
    logic [7:0]     head;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign push  = wr_req & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= dbus_write_data_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_req && full && !pop) ovf_q <= 1'b1;
            else if (ovf_clr)           ovf_q <= 1'b0;
        end
    end

    // ---------------- serializer FSM ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Every non-idle state holds its bit for CLKS_PER_BIT cycles.
        if (state_q != S_IDLE && !bit_end) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    cnt_d   = CNT_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = 3'd0;
                    cnt_d   = CNT_RELOAD;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    cnt_d   = CNT_RELOAD;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit so frames stay gapless.
                    if (!empty) begin
                        pop     = 1'b1;
                        tx_d    = 1'b0;
                        cnt_d   = CNT_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Popped byte is captured here so both pop sites share one load path.
        if (pop) begin
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end
    end

    assign tx_o = tx_q;

    // ---------------- read side ----------------
    always_comb begin
        dbus_read_data_o = 32'h0;
        if (sel_status) begin
            dbus_read_data_o = {27'b0, PARITY_FLAG, ovf_q, (state_q != S_IDLE), empty, full};
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    logic        clk_i;
    logic        rst_ni;
    logic [3:0]  dbus_en_i;
    logic [31:0] dbus_addr_i;
    logic [31:0] dbus_write_data_i;
    logic        dbus_sel_o;
    logic [31:0] dbus_read_data_o;
    logic        tx_o;

    uart_tx_mmio #(
        .CLKS_PER_BIT(4),
        .BASE_ADDR   (32'h0000_1000),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .dbus_en_i        (dbus_en_i),
        .dbus_addr_i      (dbus_addr_i),
        .dbus_write_data_i(dbus_write_data_i),
        .dbus_sel_o       (dbus_sel_o),
        .dbus_read_data_o (dbus_read_data_o),
        .tx_o             (tx_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    int         start_q [$];
    int         rx_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] en, input logic [31:0] d,
                      input logic exp_push);
        dbus_addr_i       = a;
        dbus_en_i         = en;
        dbus_write_data_i = d;
        if (exp_push) sb.push_back(d[7:0]);
        @(posedge clk_i);
        #1;
        dbus_en_i = 4'b0;
    endtask

    task automatic chk_status(input string name, input logic [31:0] exp);
        dbus_addr_i = 32'h1004;
        #1;
        chk(name, dbus_read_data_o, exp);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Serial monitor: samples every bit at all four negedges, requires a stable level,
    // start=0, stop=1, then compares the data byte against the scoreboard.
    logic [9:0] mon_bits;
    logic       mon_stable;
    logic       mon_abort;
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && tx_o === 1'b0) begin
                start_q.push_back(cyc);
                mon_stable = 1'b1;
                mon_abort  = 1'b0;
                mon_bits   = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b != 0 || k != 0) @(negedge clk_i);
                        if (!rst_ni) begin
                            mon_abort = 1'b1;
                            break;
                        end
                        if (k == 0) mon_bits[b] = tx_o;
                        else if (tx_o !== mon_bits[b]) mon_stable = 1'b0;
                    end
                    if (mon_abort) break;
                end
                if (!mon_abort) begin
                    rx_cnt++;
                    chk("frame_shape", {29'b0, mon_stable, mon_bits[0], mon_bits[9]}, 32'h5);
                    chk("frame_expected", {31'b0, sb.size() != 0}, 32'h1);
                    if (sb.size() != 0) chk("frame_data", {24'b0, mon_bits[8:1]}, {24'b0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic        sel;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [6];

    int   w0, rx0;
    logic tx_all;

    initial begin
        vecs[0] = '{32'h0000_1004, 1'b1, 32'h0000_0002};
        vecs[1] = '{32'h0000_0FFC, 1'b0, 32'h0000_0000};
        vecs[2] = '{32'h0000_1000, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'h0000_1008, 1'b0, 32'h0000_0000};
        vecs[4] = '{32'h0000_1005, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0000};

        dbus_en_i         = 4'b0;
        dbus_addr_i       = 32'h0;
        dbus_write_data_i = 32'h0;
        rst_ni            = 1'b1;
        #2 rst_ni = 1'b0;
        #1 chk("reset_tx_async", {31'b0, tx_o}, 32'h1);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset-state register decode table.
        chk("reset_tx", {31'b0, tx_o}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            dbus_addr_i = vecs[i].addr;
            #1;
            chk($sformatf("decode_sel[%0d]", i), {31'b0, dbus_sel_o}, {31'b0, vecs[i].sel});
            chk($sformatf("decode_rdata[%0d]", i), dbus_read_data_o, vecs[i].rdata);
        end
        @(posedge clk_i);
        #1;

        // Single frame 0x55: start one edge after the write, busy mid-frame, idle after 40 cycles.
        start_q.delete();
        rx0 = rx_cnt;
        wr(32'h1000, 4'b0001, 32'h55, 1'b1);
        w0 = cyc;
        wait_until(w0 + 20);
        chk_status("status_busy_mid_frame", 32'h6);
        wait_until(w0 + 41);
        chk_status("status_after_frame", 32'h2);
        chk("frame_count_55", rx_cnt - rx0, 1);
        chk("start_latency", start_q.size() > 0 ? start_q[0] : -1, w0 + 1);

        // Three back-to-back writes: gapless 40-cycle frames.
        wait_until(w0 + 45);
        start_q.delete();
        rx0 = rx_cnt;
        wr(32'h1000, 4'b0001, 32'h41, 1'b1);
        wr(32'h1000, 4'b0001, 32'h42, 1'b1);
        wr(32'h1000, 4'b0001, 32'h43, 1'b1);
        w0 = cyc - 2;
        wait_until(w0 + 125);
        chk("burst3_frames", rx_cnt - rx0, 3);
        chk("burst3_starts", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("burst3_first_start", start_q[0], w0 + 1);
            chk("burst3_gap_1", start_q[1] - start_q[0], 40);
            chk("burst3_gap_2", start_q[2] - start_q[1], 40);
        end
        chk_status("burst3_idle", 32'h2);

        // Ten writes: one popped, eight queued, tenth dropped with overflow.
        wait_until(w0 + 130);
        rx0 = rx_cnt;
        for (int i = 0; i < 10; i++) begin
            wr(32'h1000, 4'b0001, 32'h60 + i, i < 9);
        end
        w0 = cyc - 9;
        chk_status("overflow_status", 32'hD);
        wr(32'h1004, 4'b0001, 32'h8, 1'b0);
        chk_status("overflow_cleared", 32'h5);
        wait_until(w0 + 1 + 9 * 40 + 3);
        chk("overflow_frames", rx_cnt - rx0, 9);
        chk("scoreboard_drained", sb.size(), 0);
        chk_status("overflow_idle", 32'h2);

        // Write on lane 1 only: nothing is queued.
        @(posedge clk_i);
        #1;
        rx0 = rx_cnt;
        wr(32'h1000, 4'b0010, 32'hAA, 1'b0);
        tx_all = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i);
            #1;
            tx_all = tx_all & tx_o;
        end
        chk("lane1_tx_idle", {31'b0, tx_all}, 32'h1);
        chk_status("lane1_status", 32'h2);
        chk("lane1_no_frame", rx_cnt - rx0, 0);

        // Reset in the middle of a data bit with three bytes queued.
        @(posedge clk_i);
        #1;
        wr(32'h1000, 4'b0001, 32'h00, 1'b1);
        wr(32'h1000, 4'b0001, 32'h00, 1'b1);
        wr(32'h1000, 4'b0001, 32'h00, 1'b1);
        wr(32'h1000, 4'b0001, 32'h00, 1'b1);
        w0 = cyc - 3;
        wait_until(w0 + 11);
        chk("pre_reset_tx_low", {31'b0, tx_o}, 32'h0);
        #3 rst_ni = 1'b0;
        sb.delete();
        #1 chk("midframe_reset_tx", {31'b0, tx_o}, 32'h1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        rx0 = rx_cnt;
        chk_status("post_reset_status", 32'h2);
        w0 = cyc;
        wait_until(w0 + 100);
        chk("post_reset_no_frames", rx_cnt - rx0, 0);
        chk("post_reset_tx", {31'b0, tx_o}, 32'h1);
        chk_status("post_reset_status_late", 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
